dist_packet_reader: RTL

- Drains one completed telegram payload from the ping-pong distance RAM (byte-wide, bank bit plus 10-bit address) and frames it as a byte stream for the W5500 socket TX path.
- Triggered by the packet-make pulse and header fields from the distance packet writer.
- Emits a fixed header, then 4*N payload bytes (dist hi, dist lo, rssi hi, rssi lo per point), then an XOR checksum.
- Uses a valid/ready byte handshake on the output.

---
 rtl/dist_packet_reader.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/dist_packet_reader.sv
// dist_packet_reader: drains one completed bank of the ping-pong distance RAM
// and frames it as a byte stream (sync, header, payload, XOR checksum) for
// the socket TX path, using a valid/ready byte handshake.
module dist_packet_reader #(
    parameter logic [7:0] SYNC0      = 8'hA5,
    parameter logic [7:0] SYNC1      = 8'h5A,
    parameter int         MAX_POINTS = 128
) (
    input  logic        i_clk_50m,
    input  logic        i_rst_n,
    input  logic        i_tx_enable,
    input  logic        i_packet_make,
    input  logic        i_packet_pingpang,
    input  logic [15:0] i_scan_counter,
    input  logic [7:0]  i_telegram_no,
    input  logic [15:0] i_first_angle,
    input  logic [15:0] i_packet_points,
    output logic        o_ram_rden,
    output logic        o_ram_rdbank,
    output logic [9:0]  o_ram_rdaddr,
    input  logic [7:0]  i_ram_rddata,
    output logic        o_tx_valid,
    output logic [7:0]  o_tx_data,
    input  logic        i_tx_ready,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic [1:0]  o_err
);

    localparam logic [15:0] MAX_PTS  = 16'(MAX_POINTS);
    localparam logic [3:0]  HDR_LAST = 4'd10;

    typedef enum logic [2:0] {IDLE, HDR, RD_REQ, RD_LAT, PAY, CKS} state_t;

    state_t      state, state_nxt;

    logic        pend_valid;
    logic        pend_bank;
    logic [15:0] pend_scan;
    logic [7:0]  pend_tel;
    logic [15:0] pend_first;
    logic [15:0] pend_points;

    logic        act_bank;
    logic [15:0] act_scan;
    logic [7:0]  act_tel;
    logic [15:0] act_first;
    logic [15:0] act_points;

    logic [3:0]  hdr_idx;
    logic [9:0]  pay_idx;
    logic [7:0]  pay_data;
    logic [7:0]  cks;
    logic        done_q;
    logic [1:0]  err_q;

    logic        xfer;
    logic        launch;
    logic        make_ok;
    logic        bad_count;
    logic [15:0] frame_len;
    logic [9:0]  pay_total;

    assign xfer      = o_tx_valid & i_tx_ready;
    assign launch    = (state == IDLE) && pend_valid;
    assign make_ok   = i_packet_make && i_tx_enable;
    assign bad_count = (i_packet_points == 16'd0) || (i_packet_points > MAX_PTS);
    assign frame_len = 16'd12 + {act_points[13:0], 2'b00};
    assign pay_total = {act_points[7:0], 2'b00};

    assign o_busy       = (state != IDLE);
    assign o_frame_done = done_q;
    assign o_err        = err_q;

    // State register; reset abandons any partial frame and drops valid at once.
    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state decode plus the byte presented on the TX port and the RAM strobe.
    always_comb begin
        state_nxt    = state;
        o_tx_valid   = 1'b0;
        o_tx_data    = 8'h00;
        o_ram_rden   = 1'b0;
        o_ram_rdbank = 1'b0;
        o_ram_rdaddr = 10'd0;
        case (state)
            IDLE: begin
                if (pend_valid) state_nxt = HDR;
            end
            HDR: begin
                o_tx_valid = 1'b1;
                case (hdr_idx)
                    4'd0:    o_tx_data = SYNC0;
                    4'd1:    o_tx_data = SYNC1;
                    4'd2:    o_tx_data = frame_len[15:8];
                    4'd3:    o_tx_data = frame_len[7:0];
                    4'd4:    o_tx_data = act_scan[15:8];
                    4'd5:    o_tx_data = act_scan[7:0];
                    4'd6:    o_tx_data = act_tel;
                    4'd7:    o_tx_data = act_first[15:8];
                    4'd8:    o_tx_data = act_first[7:0];
                    4'd9:    o_tx_data = act_points[15:8];
                    default: o_tx_data = act_points[7:0];
                endcase
                if (xfer && hdr_idx == HDR_LAST) state_nxt = RD_REQ;
            end
            RD_REQ: begin
                o_ram_rden   = 1'b1;
                o_ram_rdbank = act_bank;
                o_ram_rdaddr = pay_idx;
                state_nxt    = RD_LAT;
            end
            RD_LAT: begin
                state_nxt = PAY;
            end
            PAY: begin
                o_tx_valid = 1'b1;
                o_tx_data  = pay_data;
                if (xfer) begin
                    if (pay_idx + 10'd1 == pay_total) state_nxt = CKS;
                    else                              state_nxt = RD_REQ;
                end
            end
            CKS: begin
                o_tx_valid = 1'b1;
                o_tx_data  = cks;
                if (xfer) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One-deep pending slot for make requests plus the sticky error flags.
    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend_valid  <= 1'b0;
            pend_bank   <= 1'b0;
            pend_scan   <= 16'd0;
            pend_tel    <= 8'd0;
            pend_first  <= 16'd0;
            pend_points <= 16'd0;
            err_q       <= 2'b00;
        end else begin
            if (launch) pend_valid <= 1'b0;
            if (make_ok) begin
                if (bad_count) begin
                    err_q[1] <= 1'b1;
                end else if (pend_valid && !launch) begin
                    err_q[0] <= 1'b1;
                end else begin
                    pend_valid  <= 1'b1;
                    pend_bank   <= ~i_packet_pingpang;
                    pend_scan   <= i_scan_counter;
                    pend_tel    <= i_telegram_no;
                    pend_first  <= i_first_angle;
                    pend_points <= i_packet_points;
                end
            end
        end
    end

    // Frame datapath: active header, byte indices, payload byte and running checksum.
    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            act_bank   <= 1'b0;
            act_scan   <= 16'd0;
            act_tel    <= 8'd0;
            act_first  <= 16'd0;
            act_points <= 16'd0;
            hdr_idx    <= 4'd0;
            pay_idx    <= 10'd0;
            pay_data   <= 8'h00;
            cks        <= 8'h00;
            done_q     <= 1'b0;
        end else begin
            done_q <= (state == CKS) && xfer;
            if (launch) begin
                act_bank   <= pend_bank;
                act_scan   <= pend_scan;
                act_tel    <= pend_tel;
                act_first  <= pend_first;
                act_points <= pend_points;
                hdr_idx    <= 4'd0;
                pay_idx    <= 10'd0;
                cks        <= 8'h00;
            end
            if (state == HDR && xfer) begin
                hdr_idx <= hdr_idx + 4'd1;
                if (hdr_idx >= 4'd2) cks <= cks ^ o_tx_data;
            end
            if (state == RD_LAT) pay_data <= i_ram_rddata;
            if (state == PAY && xfer) begin
                pay_idx <= pay_idx + 10'd1;
                cks     <= cks ^ o_tx_data;
            end
        end
    end

endmodule
